// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared pipeline types and helpers for the ARM hazard controller
package arm_pipe_pkg;
  typedef struct packed {
    logic       valid;
    logic       rd_we;
    logic [3:0] rd;
    logic       is_load;
    logic       cpsr_we;
  } stage_info_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10} fwd_sel_e;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_e;
  localparam logic [3:0] PC_REG = 4'd15;
  function automatic logic hits(stage_info_t s, logic [3:0] r);
    return s.valid && s.rd_we && s.rd == r;
  endfunction
endpackage

// File: rtl/arm_fwd_match.sv
// arm_fwd_match: per-operand producer match against the EX and MEM shadow stages
module arm_fwd_match import arm_pipe_pkg::*; (
  input  logic        used,
  input  logic [3:0]  src,
  input  stage_info_t ex,
  input  stage_info_t mem,
  output fwd_sel_e    sel,
  output logic        load_hit
);
  logic live, ex_hit, mem_hit, unused_ok;
  assign live = used && src != PC_REG;
  assign ex_hit = live && hits(ex, src);
  assign mem_hit = live && hits(mem, src);
  assign load_hit = ex_hit && ex.is_load;
  assign unused_ok = ^{ex.cpsr_we, mem.is_load, mem.cpsr_we};
  // youngest producer wins; WB needs nothing since the regfile is write-through
  always_comb sel = ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/arm_hazard_ctrl.sv
// arm_hazard_ctrl: forwarding, load-use stall, redirect flush and SWI drain control
module arm_hazard_ctrl import arm_pipe_pkg::*; #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [2:0]             id_read_mask,
  input  logic [11:0]            id_read_reg,
  input  logic                   id_rd_we,
  input  logic [3:0]             id_rd,
  input  logic                   id_is_load,
  input  logic                   id_cpsr_we,
  input  logic                   id_uses_flags,
  input  logic                   id_halt,
  input  logic                   ex_redirect,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic [5:0]             fwd_sel,
  output logic [1:0]             cpsr_fwd,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  stage_info_t ex_q, mem_q, wb_q;
  halt_state_e state;
  logic [1:0] cnt;
  fwd_sel_e sel [3];
  logic [2:0] load_hit;
  logic run, load_use, stall, unused_ok;
  for (genvar k = 0; k < 3; k++) begin : g_op
    arm_fwd_match u_match (
      .used(id_read_mask[k]),
      .src(id_read_reg[4*k +: 4]),
      .ex(ex_q),
      .mem(mem_q),
      .sel(sel[k]),
      .load_hit(load_hit[k])
    );
  end
  assign run = state == RUN;
  assign load_use = id_valid && |load_hit;
  assign stall = run && load_use && !ex_redirect;
  assign pc_stall = stall || !run;
  assign ifid_stall = pc_stall;
  assign ifid_flush = ex_redirect;
  assign idex_bubble = ex_redirect || stall || state == DRAIN;
  assign unused_ok = ^wb_q;
  // flags come from the youngest in-flight flag writer
  always_comb cpsr_fwd = !id_uses_flags ? 2'b00 : ex_q.cpsr_we ? 2'b01 : mem_q.cpsr_we ? 2'b10 : 2'b00;
  // shadow pipeline, registered operand selects and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      fwd_sel <= '0;
      stall_cycles <= '0;
    end else begin
      ex_q <= (idex_bubble || !id_valid) ? '0 : {1'b1, id_rd_we, id_rd, id_is_load, id_cpsr_we};
      mem_q <= ex_q;
      wb_q <= mem_q;
      fwd_sel <= (idex_bubble || !id_valid) ? '0 : {sel[2], sel[1], sel[0]};
      stall_cycles <= stall_cycles + STALL_CNT_W'(stall);
    end
  end
  // SWI drain: three bubble cycles flush older work, then halt until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: if (id_valid && id_halt && !ex_redirect && !load_use) begin
          state <= DRAIN;
          cnt <= '0;
        end
        DRAIN: if (cnt == 2'd2) begin
          state <= HALTED;
          halted <= 1'b1;
        end else cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end
endmodule
